// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/result bus of mult_div_unit (abort signal present under MULT_DIV_ABORT_EN)
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
`ifdef MULT_DIV_ABORT_EN
   logic             abort;
`endif

   // Control unit side: issues operations and observes results
   modport master (
      output start, op, operand_a, operand_b,
`ifdef MULT_DIV_ABORT_EN
      output abort,
`endif
      input  busy, done, hi, lo, div_by_zero
   );

   // Arithmetic unit side
   modport slave (
      input  start, op, operand_a, operand_b,
`ifdef MULT_DIV_ABORT_EN
      input  abort,
`endif
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO results (optional abort: MULT_DIV_ABORT_EN)
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic          clock,
   input  logic          reset,
   mult_div_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;         // {accumulator/remainder, multiplier/quotient}
   logic [WIDTH-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
   logic [WIDTH-1:0]   a_raw_q, a_raw_d; // raw dividend, reported as remainder on divide-by-zero
   logic [1:0]         op_q, op_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               bz_q, bz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;

   // Operand magnitudes for signed ops, radix-2 step datapaths and final sign fix-up
   always_comb begin
      a_mag    = (bus.op[0] && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
      b_mag    = (bus.op[0] && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
      mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, p_q[WIDTH-1:1]};
      div_diff = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      div_next = div_diff[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      prod_fix = (op_q[0] && (sa_q ^ sb_q)) ? -p_q : p_q;
      quo_fix  = (op_q[0] && (sa_q ^ sb_q)) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      rem_fix  = (op_q[0] && sa_q) ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and datapath control for IDLE -> RUN -> FIX -> IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      b_d     = b_q;
      a_raw_d = a_raw_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bz_d    = bz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               sa_d    = bus.op[0] & bus.operand_a[WIDTH-1];
               sb_d    = bus.op[0] & bus.operand_b[WIDTH-1];
               p_d     = {{WIDTH{1'b0}}, a_mag};
               b_d     = b_mag;
               a_raw_d = bus.operand_a;
               bz_d    = (bus.operand_b == '0);
               cnt_d   = CNT_LOAD;
               dbz_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            p_d = op_q[1] ? div_next : mul_next;
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (bz_q) begin
               hi_d  = a_raw_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef MULT_DIV_ABORT_EN
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dbz_d   = dbz_q;
         done_d  = 1'b0;
      end
`endif
   end

   // State and datapath registers, cleared immediately by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         b_q     <= '0;
         a_raw_q <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         b_q     <= b_d;
         a_raw_q <= a_raw_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference results from plain integer arithmetic
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
      logic [63:0] p;
      longint      sa, sb, q, r;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      edbz = 1'b0;
      p    = '0;
      case (op)
         2'd0: p = {32'd0, a} * {32'd0, b};
         2'd1: p = 64'(sa * sb);
         default: begin
            if (b == 32'd0) begin
               edbz = 1'b1;
               p    = {a, 32'hFFFF_FFFF};
            end else if (op == 2'd2) begin
               p = {a % b, a / b};
            end else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      ehi = p[63:32];
      elo = p[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One full operation; a stray start pulse is injected at cycle 'glitch' after the start edge
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int glitch);
      logic [31:0] ehi, elo;
      logic        edbz;
      int          k;
      model(op, a, b, ehi, elo, edbz);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 2'($urandom_range(0, 3));
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      chk("dbz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
      k = 0;
      while (bus.done !== 1'b1 && k < 60) begin
         if (k == glitch) begin
            bus.start = 1'b1;
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      chk("done_latency", 64'(k), 64'd33);
      chk("busy_in_done_cycle", 64'(bus.busy), 64'd0);
      chk("hi", 64'(bus.hi), 64'(ehi));
      chk("lo", 64'(bus.lo), 64'(elo));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(edbz));
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_done", 64'(bus.busy), 64'd0);
      chk("done_single_cycle", 64'(bus.done), 64'd0);
   endtask

   initial begin
      int          dones;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          sel;
      bus.start = 1'b0;
      bus.op = 2'd0;
      bus.operand_a = '0;
      bus.operand_b = '0;
`ifdef MULT_DIV_ABORT_EN
      bus.abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      rst = 1'b0;

      do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      do_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, -1);
      do_op(2'd2, 32'd100, 32'd7, -1);
      do_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1);
      do_op(2'd2, 32'd5, 32'd0, -1);
      do_op(2'd0, 32'd2, 32'd3, -1);
      do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      do_op(2'd3, 32'hFFFF_FFFB, 32'd0, -1);
      do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32);
      do_op(2'd0, 32'd3, 32'd4, 4);

      // Reset in the middle of an operation: results clear at once, no done ever follows
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'd0;
      bus.operand_a = 32'd5;
      bus.operand_b = 32'd6;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hi", 64'(bus.hi), 64'd0);
      chk("midrst_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      chk("midrst_no_done", 64'(dones), 64'd0);
      chk("midrst_idle", 64'(bus.busy), 64'd0);

`ifdef MULT_DIV_ABORT_EN
      do_op(2'd2, 32'd100, 32'd7, -1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'd0;
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd14);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
      do_op(2'd0, 32'd9, 32'd9, -1);
`endif

      for (int i = 0; i < 20; i++) begin
         sel = $urandom_range(0, 5);
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) rb = 32'd0;
         if (sel == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if (sel == 2) rb = $urandom_range(1, 15);
         do_op(rop, ra, rb, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit sitting directly downstream of the register file.
- Consumes the two register read operands (data_out_1 / data_out_2) when the control unit issues a start.
- Computes a 64-bit product or a quotient/remainder pair into HI/LO result registers.
- The control unit stalls on busy; the writeback mux later selects hi/lo for the write_data_in path.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each, product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00=MULTU, 01=MULT (signed), 10=DIVU, 11=DIV (signed).
- operand_a  input  WIDTH  multiplicand / dividend (register file data_out_1).
- operand_b  input  WIDTH  multiplier / divisor (register file data_out_2).
- busy  output  1  high while an operation is in progress (RUN or FIX).
- done  output  1  one-cycle pulse; hi/lo are valid in the same cycle.
- hi  output  WIDTH  product[2W-1:W] or remainder.
- lo  output  WIDTH  product[W-1:0] or quotient.
- div_by_zero  output  1  set on completion of a divide with operand_b==0; cleared on the next accepted start.

Behaviour:
- Reset: takes effect immediately, at any time including mid-operation. State -> IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. An in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - On a posedge with start=1: latch op and operand sign bits.
  - Load the magnitudes of a and b; magnitudes are used only for signed ops, raw values otherwise.
  - Clear the accumulator, load counter=WIDTH-1, clear div_by_zero, go to RUN.
- RUN: one radix-2 step per cycle (shift-add multiply; restoring shift-subtract divide). Counter decrements each cycle; when counter==0, go to FIX. RUN lasts exactly WIDTH cycles.
- FIX: apply sign correction and write hi/lo, pulse done=1 for this single cycle, then go to IDLE.
- Latency: if start is sampled at edge N, busy is high from edge N through edge N+WIDTH+1. done is high and hi/lo are updated in the cycle following edge N+WIDTH+1, i.e. 33 edges after start for WIDTH=32. done is registered and busy is low in that cycle.
- hi/lo hold their value until the next FIX or reset; they are never modified during RUN.
- Signed rules:
  - MULT: negate the 2W product if sign_a XOR sign_b.
  - DIV: quotient negative if sign_a XOR sign_b; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural truncation, no trap).
- Divide by zero: runs the full WIDTH cycles, then lo=all ones, hi=operand_a as latched (unsigned raw value), div_by_zero=1. No sign correction is applied.
- start while busy=1 is ignored; no queueing.
- start asserted in the FIX cycle is also ignored.
- Operands are captured at the start edge only; later operand changes have no effect.
- op=MULT/MULTU never sets div_by_zero.

Optional Feature:
- Macro MULT_DIV_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 at a posedge in RUN or FIX returns the unit to IDLE at that edge: busy=0 next cycle, no done pulse, hi/lo/div_by_zero unchanged.
  - abort in IDLE has no effect. If start and abort coincide in IDLE, start wins.
- When undefined: no abort port; an operation always runs to completion unless reset is asserted.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001, busy low in the done cycle.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIVU 100/7 -> lo=14, hi=2; then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_by_zero=0 for both.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1; next MULTU 2*3 start clears the flag, giving lo=6, hi=0.
- MULTU 3*4 started; pulse start again with different operands at edge +5 (ignored) -> lo=12; assert reset at edge +10 of a second op -> busy=0, hi=lo=0 immediately, no done pulse.
- (MULT_DIV_ABORT_EN) DIVU 100/7 completes (lo=14); start MULTU 9*9, abort at edge +4 -> busy drops, no done, lo stays 14; a new start is accepted on the next cycle.
